// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID
// pipeline register, with stall, flush, branch redirect, run gating and fetch counter.
module if_stage #(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int unsigned      CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             branch_i,
   input  logic [XLEN-1:0]  branch_target_i,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic [31:0]      imem_inst_i,
   output logic [XLEN-1:0]  if_id_pc4_o,
   output logic [31:0]      if_id_inst_o,
   output logic             if_id_valid_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] fetch_count_o
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;

   assign pc_plus4    = pc + XLEN'(4);
   assign imem_addr_o = pc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc            <= RESET_PC;
         if_id_pc4_o   <= '0;
         if_id_inst_o  <= '0;
         if_id_valid_o <= 1'b0;
         misalign_o    <= 1'b0;
         fetch_count_o <= '0;
      end else if (stall_i) begin
         // Redirects seen during a stall are dropped; ID re-presents them afterwards.
         misalign_o <= 1'b0;
      end else if (branch_i) begin
         pc            <= {branch_target_i[XLEN-1:2], 2'b00};
         if_id_pc4_o   <= '0;
         if_id_inst_o  <= '0;
         if_id_valid_o <= 1'b0;
         misalign_o    <= |branch_target_i[1:0];
      end else if (flush_i) begin
         if (start_i)
            pc <= pc_plus4;
         if_id_pc4_o   <= '0;
         if_id_inst_o  <= '0;
         if_id_valid_o <= 1'b0;
         misalign_o    <= 1'b0;
      end else if (!start_i) begin
         if_id_pc4_o   <= '0;
         if_id_inst_o  <= '0;
         if_id_valid_o <= 1'b0;
         misalign_o    <= 1'b0;
      end else begin
         pc            <= pc_plus4;
         if_id_pc4_o   <= pc_plus4;
         if_id_inst_o  <= imem_inst_i;
         if_id_valid_o <= 1'b1;
         misalign_o    <= 1'b0;
         fetch_count_o <= fetch_count_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table plus short hand-written
// sequences for counter wrap and misalign pulse behaviour.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst, start, stall, flush, branch;
   logic [31:0] tgt;

   logic [31:0] addr32, pc4_32, inst32, ifid32;
   logic        valid32, mis32;
   logic [31:0] cnt32;

   logic [31:0] addr4, pc4_4, inst4, ifid4;
   logic        valid4, mis4;
   logic [3:0]  cnt4;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   assign inst32 = mem_word(addr32);
   assign inst4  = mem_word(addr4);

   if_stage #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
      .branch_i(branch), .branch_target_i(tgt), .imem_addr_o(addr32),
      .imem_inst_i(inst32), .if_id_pc4_o(pc4_32), .if_id_inst_o(ifid32),
      .if_id_valid_o(valid32), .misalign_o(mis32), .fetch_count_o(cnt32)
   );

   if_stage #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
      .branch_i(branch), .branch_target_i(tgt), .imem_addr_o(addr4),
      .imem_inst_i(inst4), .if_id_pc4_o(pc4_4), .if_id_inst_o(ifid4),
      .if_id_valid_o(valid4), .misalign_o(mis4), .fetch_count_o(cnt4)
   );

   typedef struct {
      logic        rst, start, stall, flush, branch;
      logic [31:0] tgt;
      logic [31:0] addr, pc4;
      logic        valid, mis;
      logic [31:0] cnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t vec(input logic r, s, st, fl, br, input logic [31:0] t,
                                input logic [31:0] a, p, input logic v, m,
                                input logic [31:0] c);
      vec_t x;
      x.rst = r; x.start = s; x.stall = st; x.flush = fl; x.branch = br; x.tgt = t;
      x.addr = a; x.pc4 = p; x.valid = v; x.mis = m; x.cnt = c;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later.
   task automatic step(input string tag, input vec_t v);
      logic [31:0] exp_inst;
      rst = v.rst; start = v.start; stall = v.stall; flush = v.flush;
      branch = v.branch; tgt = v.tgt;
      @(posedge clk);
      #1;
      exp_inst = v.valid ? mem_word(v.pc4 - 32'd4) : 32'h0;
      chk({tag, " addr"},  addr32,  v.addr);
      chk({tag, " pc4"},   pc4_32,  v.pc4);
      chk({tag, " inst"},  ifid32,  exp_inst);
      chk({tag, " valid"}, {31'b0, valid32}, {31'b0, v.valid});
      chk({tag, " mis"},   {31'b0, mis32},   {31'b0, v.mis});
      chk({tag, " cnt"},   cnt32,   v.cnt);
      chk({tag, " cnt4"},  {28'b0, cnt4},    {28'b0, v.cnt[3:0]});
      chk({tag, " addr4"}, addr4,   v.addr);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; branch = 1'b0; tgt = '0;

      //            rst st stl fl br  tgt            addr           pc4         v  m  cnt
      vt.push_back(vec(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,      0, 0, 0));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'h4,         32'h4,      1, 0, 1));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'h8,         32'h8,      1, 0, 2));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'hC,         32'hC,      1, 0, 3));
      vt.push_back(vec(0, 1, 1, 0, 0, 32'h0,         32'hC,         32'hC,      1, 0, 3));
      vt.push_back(vec(0, 1, 1, 0, 0, 32'h0,         32'hC,         32'hC,      1, 0, 3));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'h10,        32'h10,     1, 0, 4));
      vt.push_back(vec(0, 1, 0, 0, 1, 32'h40,        32'h40,        32'h0,      0, 0, 4));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'h44,        32'h44,     1, 0, 5));
      vt.push_back(vec(0, 1, 1, 0, 1, 32'h80,        32'h44,        32'h44,     1, 0, 5));
      vt.push_back(vec(0, 1, 0, 0, 1, 32'h43,        32'h40,        32'h0,      0, 1, 5));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'h44,        32'h44,     1, 0, 6));
      vt.push_back(vec(0, 1, 0, 0, 1, 32'h20,        32'h20,        32'h0,      0, 0, 6));
      vt.push_back(vec(0, 1, 0, 1, 0, 32'h0,         32'h24,        32'h0,      0, 0, 6));
      vt.push_back(vec(0, 0, 0, 0, 0, 32'h0,         32'h24,        32'h0,      0, 0, 6));
      vt.push_back(vec(0, 0, 0, 0, 0, 32'h0,         32'h24,        32'h0,      0, 0, 6));
      vt.push_back(vec(0, 0, 0, 0, 0, 32'h0,         32'h24,        32'h0,      0, 0, 6));
      vt.push_back(vec(0, 0, 0, 1, 0, 32'h0,         32'h24,        32'h0,      0, 0, 6));
      vt.push_back(vec(0, 0, 0, 0, 1, 32'h30,        32'h30,        32'h0,      0, 0, 6));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'h34,        32'h34,     1, 0, 7));
      vt.push_back(vec(0, 1, 0, 1, 1, 32'h50,        32'h50,        32'h0,      0, 0, 7));
      vt.push_back(vec(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      0, 0, 7));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0,      1, 0, 8));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'h4,         32'h4,      1, 0, 9));
      vt.push_back(vec(0, 1, 1, 0, 0, 32'h0,         32'h4,         32'h4,      1, 0, 9));
      vt.push_back(vec(1, 1, 1, 0, 1, 32'h80,        32'h0,         32'h0,      0, 0, 0));
      vt.push_back(vec(0, 1, 0, 0, 0, 32'h0,         32'h4,         32'h4,      1, 0, 1));

      foreach (vt[i]) step($sformatf("v%0d", i), vt[i]);

      // Fifteen more fetches: 16 total since reset, so the 4-bit counter wraps to 0.
      for (int i = 1; i <= 15; i++) begin
         logic [31:0] a;
         a = 32'd4 + 32'd4 * i;
         step($sformatf("wrap%0d", i), vec(0, 1, 0, 0, 0, 32'h0, a, a, 1, 0, 32'd1 + i));
      end
      chk("cnt32 after 16", cnt32, 32'd16);
      chk("cnt4 wrapped", {28'b0, cnt4}, 32'd0);

      // Misaligned redirect pulses once; a stall in the next cycle clears it.
      step("mis_set",   vec(0, 1, 0, 0, 1, 32'h41, 32'h40, 32'h0,  0, 1, 16));
      step("mis_stall", vec(0, 1, 1, 0, 1, 32'h43, 32'h40, 32'h0,  0, 0, 16));
      step("mis_after", vec(0, 1, 0, 0, 0, 32'h0,  32'h44, 32'h44, 1, 0, 17));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
